// File: rtl/partitioned_assoc_cache.sv
// partitioned_assoc_cache
//   Set-associative, write-back / write-allocate cache split into PARTS
//   isolated partitions (SETS sets x WAYS ways each, one word per line).
//   Replacement: lowest-numbered invalid way, otherwise the way with the
//   smallest saturating access counter (ties go to the lowest way).
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req_*               core request (valid/ready), part-select in req_part
//   resp_*              one-cycle response pulse with read data and hit flag
//   mem_req_*           backing-memory request (writeback or fill read)
//   mem_resp_*          fill data return
//   flush_valid/part    invalidate one partition, writing back dirty lines
//   flush_done          one-cycle pulse when the flush has finished
module partitioned_assoc_cache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int PARTS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [$clog2(PARTS)-1:0] req_part,
  output logic                     resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     resp_hit,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [DATA_W-1:0]        mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic [DATA_W-1:0]        mem_resp_rdata,
  input  logic                     flush_valid,
  input  logic [$clog2(PARTS)-1:0] flush_part,
  output logic                     flush_done
);

  localparam int PW = $clog2(PARTS);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - IW;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, RESP, FLUSH_SCAN, FLUSH_WB
  } state_t;

  state_t state;

  logic [PARTS-1:0][SETS-1:0][WAYS-1:0]             valid_q, dirty_q;
  logic [PARTS-1:0][SETS-1:0][WAYS-1:0][TW-1:0]     tag_q;
  logic [PARTS-1:0][SETS-1:0][WAYS-1:0][DATA_W-1:0] data_q;
  logic [PARTS-1:0][SETS-1:0][WAYS-1:0][CNT_W-1:0]  cnt_q;

  // registered request
  logic              r_we;
  logic [PW-1:0]     r_part;
  logic [IW-1:0]     r_idx;
  logic [TW-1:0]     r_tag;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_hit;
  logic [WW-1:0]     r_way;

  // flush walker
  logic [PW-1:0]     f_part;
  logic [IW-1:0]     f_set;
  logic [WW-1:0]     f_way;

  // lookup results for the registered request
  logic              hit;
  logic [WW-1:0]     hit_way;
  logic              inv_found;
  logic [WW-1:0]     inv_way;
  logic [WW-1:0]     min_way;
  logic [CNT_W-1:0]  min_cnt;
  logic [WW-1:0]     victim;
  logic              v_dirty;
  logic [TW-1:0]     v_tag;
  logic [DATA_W-1:0] v_data;

  logic              fl_dirty;
  logic              f_last;
  logic              do_install;
  logic [WW-1:0]     ins_way;
  logic              do_inval;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    min_way   = '0;
    min_cnt   = cnt_q[r_part][r_idx][WW'(0)];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[r_part][r_idx][WW'(w)] && (tag_q[r_part][r_idx][WW'(w)] == r_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!inv_found && !valid_q[r_part][r_idx][WW'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
      // strict less-than keeps ties on the lowest way
      if (cnt_q[r_part][r_idx][WW'(w)] < min_cnt) begin
        min_cnt = cnt_q[r_part][r_idx][WW'(w)];
        min_way = WW'(w);
      end
    end
    victim  = inv_found ? inv_way : min_way;
    v_dirty = valid_q[r_part][r_idx][victim] & dirty_q[r_part][r_idx][victim];
    v_tag   = tag_q[r_part][r_idx][victim];
    v_data  = data_q[r_part][r_idx][victim];

    fl_dirty = valid_q[f_part][f_set][f_way] & dirty_q[f_part][f_set][f_way];
    f_last   = (f_set == IW'(SETS - 1)) && (f_way == WW'(WAYS - 1));

    // Line installation happens from three states; it is pulled out of the
    // case statement so the write-back of the new line lives in one place.
    do_install = ((state == LOOKUP) && !hit && !v_dirty && r_we) ||
                 ((state == WB) && mem_req_ready && r_we) ||
                 ((state == FILL_WAIT) && mem_resp_valid);
    ins_way    = (state == LOOKUP) ? victim : r_way;
    do_inval   = ((state == FLUSH_SCAN) && !fl_dirty) ||
                 ((state == FLUSH_WB) && mem_req_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_hit      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      flush_done    <= 1'b0;
      valid_q       <= '0;
      dirty_q       <= '0;
      tag_q         <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      r_we          <= 1'b0;
      r_part        <= '0;
      r_idx         <= '0;
      r_tag         <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_hit         <= 1'b0;
      r_way         <= '0;
      f_part        <= '0;
      f_set         <= '0;
      f_way         <= '0;
    end else begin
      resp_valid <= 1'b0;
      flush_done <= 1'b0;

      if (do_install) begin
        tag_q[r_part][r_idx][ins_way]   <= r_tag;
        valid_q[r_part][r_idx][ins_way] <= 1'b1;
        dirty_q[r_part][r_idx][ins_way] <= r_we;
        data_q[r_part][r_idx][ins_way]  <= r_we ? r_wdata : mem_resp_rdata;
        cnt_q[r_part][r_idx][ins_way]   <= CNT_W'(1);
      end

      if (do_inval) begin
        valid_q[f_part][f_set][f_way] <= 1'b0;
        dirty_q[f_part][f_set][f_way] <= 1'b0;
        cnt_q[f_part][f_set][f_way]   <= '0;
      end

      case (state)
        IDLE: begin
          if (flush_valid) begin
            f_part    <= flush_part;
            f_set     <= '0;
            f_way     <= '0;
            req_ready <= 1'b0;
            state     <= FLUSH_SCAN;
          end else if (req_valid) begin
            r_we      <= req_we;
            r_part    <= req_part;
            r_idx     <= req_addr[IW-1:0];
            r_tag     <= req_addr[ADDR_W-1:IW];
            r_wdata   <= req_wdata;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (hit) begin
            r_hit   <= 1'b1;
            r_rdata <= data_q[r_part][r_idx][hit_way];
            if (cnt_q[r_part][r_idx][hit_way] != CNT_MAX)
              cnt_q[r_part][r_idx][hit_way] <= cnt_q[r_part][r_idx][hit_way] + CNT_W'(1);
            if (r_we) begin
              data_q[r_part][r_idx][hit_way]  <= r_wdata;
              dirty_q[r_part][r_idx][hit_way] <= 1'b1;
            end
            state <= RESP;
          end else begin
            r_hit <= 1'b0;
            r_way <= victim;
            if (v_dirty) begin
              mem_req_valid <= 1'b1;
              mem_req_we    <= 1'b1;
              mem_req_addr  <= {v_tag, r_idx};
              mem_req_wdata <= v_data;
              state         <= WB;
            end else if (!r_we) begin
              mem_req_valid <= 1'b1;
              mem_req_we    <= 1'b0;
              mem_req_addr  <= {r_tag, r_idx};
              state         <= FILL_REQ;
            end else begin
              state <= RESP;
            end
          end
        end

        WB: begin
          if (mem_req_ready) begin
            if (!r_we) begin
              // valid stays high: the fill request follows back-to-back
              mem_req_we   <= 1'b0;
              mem_req_addr <= {r_tag, r_idx};
              state        <= FILL_REQ;
            end else begin
              mem_req_valid <= 1'b0;
              state         <= RESP;
            end
          end
        end

        FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= FILL_WAIT;
          end
        end

        FILL_WAIT: begin
          if (mem_resp_valid) begin
            r_rdata <= mem_resp_rdata;
            state   <= RESP;
          end
        end

        RESP: begin
          resp_valid <= 1'b1;
          resp_hit   <= r_hit;
          resp_rdata <= r_we ? '0 : r_rdata;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end

        FLUSH_SCAN: begin
          if (fl_dirty) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b1;
            mem_req_addr  <= {tag_q[f_part][f_set][f_way], f_set};
            mem_req_wdata <= data_q[f_part][f_set][f_way];
            state         <= FLUSH_WB;
          end else if (f_last) begin
            flush_done <= 1'b1;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else if (f_way == WW'(WAYS - 1)) begin
            f_way <= '0;
            f_set <= f_set + IW'(1);
          end else begin
            f_way <= f_way + WW'(1);
          end
        end

        FLUSH_WB: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (f_last) begin
              flush_done <= 1'b1;
              req_ready  <= 1'b1;
              state      <= IDLE;
            end else begin
              if (f_way == WW'(WAYS - 1)) begin
                f_way <= '0;
                f_set <= f_set + IW'(1);
              end else begin
                f_way <= f_way + WW'(1);
              end
              state <= FLUSH_SCAN;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_partitioned_assoc_cache.sv
module tb_partitioned_assoc_cache;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int PARTS  = 4;
  localparam int SETS   = 4;
  localparam int WAYS   = 2;
  localparam int CNT_W  = 8;
  localparam int PW     = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [PW-1:0]     req_part;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;
  logic              flush_valid;
  logic [PW-1:0]     flush_part;
  logic              flush_done;

  always #5 clk = ~clk;

  partitioned_assoc_cache #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PARTS(PARTS),
    .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_part(req_part),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .flush_valid(flush_valid),
    .flush_part(flush_part), .flush_done(flush_done)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } op_t;

  op_t         ops[$];       // memory operations seen on the port
  op_t         exp_ops[$];   // operations the model predicts
  logic [31:0] mem_store   [int];
  logic [31:0] mem_preload [int];
  bit          stall_fill;
  int          inject_req;
  int          n_checks;
  int          n_pass;
  logic        last_hit;
  logic [31:0] last_rdata;

  // reference model: plain per-line records
  bit          m_valid [PARTS][SETS][WAYS];
  bit          m_dirty [PARTS][SETS][WAYS];
  int          m_tag   [PARTS][SETS][WAYS];
  logic [31:0] m_data  [PARTS][SETS][WAYS];
  int          m_cnt   [PARTS][SETS][WAYS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  function automatic logic [31:0] mem_value(input int a);
    if (mem_store.exists(a)) return mem_store[a];
    if (mem_preload.exists(a)) return mem_preload[a];
    return {16'(a) ^ 16'hA5C3, 16'(a)};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < PARTS; p++)
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          m_valid[p][s][w] = 0; m_dirty[p][s][w] = 0;
          m_tag[p][s][w] = 0; m_data[p][s][w] = '0; m_cnt[p][s][w] = 0;
        end
  endtask

  task automatic model_access(input int p, input bit we, input int a, input logic [31:0] wd,
                              output bit hit, output logic [31:0] rd);
    int s = a % SETS;
    int t = a / SETS;
    int v = -1;
    exp_ops.delete();
    hit = 0;
    rd  = '0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[p][s][w] && m_tag[p][s][w] == t) v = w;
    if (v >= 0) begin
      hit = 1;
      if (m_cnt[p][s][v] < CMAX) m_cnt[p][s][v]++;
      if (we) begin m_data[p][s][v] = wd; m_dirty[p][s][v] = 1; end
      else rd = m_data[p][s][v];
      return;
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!m_valid[p][s][w]) v = w;
    if (v < 0) begin
      v = 0;
      for (int w = 1; w < WAYS; w++)
        if (m_cnt[p][s][w] < m_cnt[p][s][v]) v = w;
    end
    if (m_valid[p][s][v] && m_dirty[p][s][v])
      exp_ops.push_back('{1'b1, 16'(m_tag[p][s][v] * SETS + s), m_data[p][s][v]});
    if (we) begin
      m_data[p][s][v]  = wd;
      m_dirty[p][s][v] = 1;
    end else begin
      rd = mem_value(a);
      exp_ops.push_back('{1'b0, 16'(a), 32'h0});
      m_data[p][s][v]  = rd;
      m_dirty[p][s][v] = 0;
    end
    m_valid[p][s][v] = 1;
    m_tag[p][s][v]   = t;
    m_cnt[p][s][v]   = 1;
  endtask

  // backing memory: random ready, fill data 1..3 cycles after the handshake
  op_t         pend;
  int          fill_cnt;
  logic [31:0] fill_data;
  int          inject_ack;

  initial begin
    pend = '0; fill_cnt = 0; fill_data = '0; inject_ack = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 0;
      if (reset) begin
        fill_cnt = 0;
        mem_req_ready = 0;
      end else begin
        if (fill_cnt > 0) begin
          fill_cnt--;
          if (fill_cnt == 0) begin mem_resp_valid = 1; mem_resp_rdata = fill_data; end
        end
        if (mem_req_ready) begin
          ops.push_back(pend);
          if (pend.we) mem_store[int'(pend.addr)] = pend.data;
          else if (!stall_fill) begin
            fill_data = mem_value(int'(pend.addr));
            fill_cnt  = $urandom_range(1, 3);
          end
        end
        if (inject_req != inject_ack) begin
          inject_ack = inject_req;
          mem_resp_valid = 1;
          mem_resp_rdata = 32'hDEADBEEF;
        end
        mem_req_ready = mem_req_valid && ($urandom_range(0, 1) == 1);
        if (mem_req_ready) pend = '{mem_req_we, mem_req_addr, mem_req_we ? mem_req_wdata : 32'h0};
      end
    end
  end

  task automatic wait_ready(input string nm);
    int cyc = 0;
    @(negedge clk);
    while (!req_ready && cyc < 100) begin @(negedge clk); cyc++; end
    if (!req_ready) check({nm, "_ready_timeout"}, 64'(req_ready), 64'(1));
  endtask

  task automatic check_ops(input string nm, input int base);
    int n = ops.size() - base;
    check({nm, "_nops"}, 64'(n), 64'(exp_ops.size()));
    for (int i = 0; i < n && i < exp_ops.size(); i++) begin
      check({nm, "_op_we"}, 64'(ops[base + i].we), 64'(exp_ops[i].we));
      check({nm, "_op_addr"}, 64'(ops[base + i].addr), 64'(exp_ops[i].addr));
      if (exp_ops[i].we) check({nm, "_op_data"}, 64'(ops[base + i].data), 64'(exp_ops[i].data));
    end
  endtask

  task automatic do_access(input int p, input bit we, input int a, input logic [31:0] wd,
                           input string nm);
    bit          eh;
    logic [31:0] erd;
    int          base;
    int          cyc;
    bit          got;
    model_access(p, we, a, wd, eh, erd);
    wait_ready(nm);
    req_valid = 1; req_we = we; req_addr = 16'(a); req_wdata = wd; req_part = PW'(p);
    base = ops.size();
    @(posedge clk);
    #1 req_valid = 0;
    cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk); cyc++;
      if (resp_valid) got = 1;
    end
    check({nm, "_resp"}, 64'(got), 64'(1));
    if (got) begin
      last_hit   = resp_hit;
      last_rdata = resp_rdata;
      check({nm, "_hit"}, 64'(resp_hit), 64'(eh));
      check({nm, "_rdata"}, 64'(resp_rdata), 64'(erd));
      if (eh) check({nm, "_latency"}, 64'(cyc - 1), 64'(2));
      @(negedge clk);
      check({nm, "_pulse"}, 64'(resp_valid), 64'(0));
      check_ops(nm, base);
    end
  endtask

  task automatic do_flush(input int p, input string nm);
    int base;
    int cyc;
    bit got;
    exp_ops.delete();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        if (m_valid[p][s][w] && m_dirty[p][s][w])
          exp_ops.push_back('{1'b1, 16'(m_tag[p][s][w] * SETS + s), m_data[p][s][w]});
        m_valid[p][s][w] = 0; m_dirty[p][s][w] = 0; m_cnt[p][s][w] = 0;
      end
    wait_ready(nm);
    flush_valid = 1; flush_part = PW'(p);
    base = ops.size();
    @(posedge clk);
    #1 flush_valid = 0;
    cyc = 0; got = 0;
    while (!got && cyc < 300) begin
      @(negedge clk); cyc++;
      if (flush_done) got = 1;
    end
    check({nm, "_done"}, 64'(got), 64'(1));
    if (got) begin
      @(negedge clk);
      check({nm, "_done_pulse"}, 64'(flush_done), 64'(0));
      check_ops(nm, base);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_req_ready"}, 64'(req_ready), 64'(1));
    check({nm, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({nm, "_resp_rdata"}, 64'(resp_rdata), 64'(0));
    check({nm, "_resp_hit"}, 64'(resp_hit), 64'(0));
    check({nm, "_mem_valid"}, 64'(mem_req_valid), 64'(0));
    check({nm, "_mem_we"}, 64'(mem_req_we), 64'(0));
    check({nm, "_mem_addr"}, 64'(mem_req_addr), 64'(0));
    check({nm, "_mem_wdata"}, 64'(mem_req_wdata), 64'(0));
    check({nm, "_flush_done"}, 64'(flush_done), 64'(0));
  endtask

  initial begin
    int base;
    int cyc;
    bit saw;
    n_checks = 0; n_pass = 0; stall_fill = 0; inject_req = 0;
    last_hit = 0; last_rdata = '0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_part = '0;
    flush_valid = 0; flush_part = '0;
    model_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    reset = 0;

    // write then read in part0
    do_access(0, 1, 'h0001, 32'hA5A5A5A5, "tp1_w");
    check("tp1_w_miss", 64'(last_hit), 64'(0));
    do_access(0, 0, 'h0001, 32'h0, "tp1_r");
    check("tp1_r_hit", 64'(last_hit), 64'(1));
    check("tp1_r_data", 64'(last_rdata), 64'(32'hA5A5A5A5));

    // read miss with fill in part2
    mem_preload[32'h21] = 32'h12345678;
    do_access(2, 0, 'h0021, 32'h0, "tp2_miss");
    check("tp2_fill_data", 64'(last_rdata), 64'(32'h12345678));
    do_access(2, 0, 'h0021, 32'h0, "tp2_rehit");
    check("tp2_rehit_hit", 64'(last_hit), 64'(1));

    // least-access-count eviction in part3 set1
    do_access(3, 1, 'h0011, 32'h11111111, "tp3_w11");
    do_access(3, 1, 'h0021, 32'h22222222, "tp3_w21");
    for (int i = 0; i < 3; i++) do_access(3, 0, 'h0011, 32'h0, "tp3_r11");
    base = ops.size();
    do_access(3, 1, 'h0031, 32'h33333333, "tp3_w31");
    check("tp3_evict_cnt", 64'(ops.size() - base), 64'(1));
    if (ops.size() > base) begin
      check("tp3_evict_we", 64'(ops[base].we), 64'(1));
      check("tp3_evict_addr", 64'(ops[base].addr), 64'(16'h0021));
    end
    do_access(3, 0, 'h0011, 32'h0, "tp3_keep");
    check("tp3_keep_hit", 64'(last_hit), 64'(1));

    // partition isolation
    do_access(0, 1, 'h0040, 32'hAAAA0000, "iso_w0");
    do_access(1, 1, 'h0040, 32'hBBBB1111, "iso_w1");
    do_access(0, 0, 'h0040, 32'h0, "iso_r0");
    check("iso_r0_data", 64'(last_rdata), 64'(32'hAAAA0000));
    do_access(1, 0, 'h0040, 32'h0, "iso_r1");
    check("iso_r1_data", 64'(last_rdata), 64'(32'hBBBB1111));

    // flush part1
    do_access(1, 1, 'h0005, 32'h55550005, "fl_w5");
    do_access(1, 1, 'h0006, 32'h66660006, "fl_w6");
    do_flush(1, "flush1");
    do_access(1, 0, 'h0005, 32'h0, "fl_r5");
    check("fl_r5_miss", 64'(last_hit), 64'(0));
    do_access(0, 0, 'h0040, 32'h0, "fl_p0");
    check("fl_p0_hit", 64'(last_hit), 64'(1));

    // reset while waiting for fill data
    stall_fill = 1;
    wait_ready("rst");
    req_valid = 1; req_we = 0; req_addr = 16'h0077; req_wdata = '0; req_part = '0;
    base = ops.size();
    @(posedge clk);
    #1 req_valid = 0;
    cyc = 0;
    while (ops.size() == base && cyc < 50) begin @(negedge clk); cyc++; end
    check("rst_fill_issued", 64'(ops.size() - base), 64'(1));
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    reset = 0;
    inject_req++;
    saw = 0;
    repeat (5) begin @(negedge clk); saw |= resp_valid; end
    check("rst_stray_resp", 64'(saw), 64'(0));
    check_reset_outputs("rst_after");
    model_reset();
    stall_fill = 0;
    do_access(0, 0, 'h0001, 32'h0, "rst_reread");
    check("rst_reread_miss", 64'(last_hit), 64'(0));

    // random traffic against the model
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 24) == 0) do_flush($urandom_range(0, PARTS - 1), "rnd_flush");
      else do_access($urandom_range(0, PARTS - 1), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 23), $urandom, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
